// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and queue entry layout for the
// ALU operation sequencer.
package alu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_SHL = 4'h6;
    localparam logic [3:0] OP_SHR = 4'h7;
    localparam logic [3:0] OP_INC = 4'h8;
    localparam logic [3:0] OP_DEC = 4'h9;

    // NOP drives nothing downstream, so it is safe to present while idle.
    localparam logic [3:0] IDLE_SEL_DEFAULT = OP_NOP;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_CAPTURE = 2'd3
    } alu_state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
    } op_entry_t;

    function automatic op_entry_t make_entry(input logic [3:0] sel, input logic [7:0] data);
        op_entry_t e;
        e.sel  = sel;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Switch/button inputs, ALU drive/return and status of the operation sequencer.
// Handshake: push/step act only on their rising edge; done is a one-cycle pulse.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic [3:0]              sw_sel;
    logic signed [7:0]       sw_data;
    logic                    push;
    logic                    step;
    logic                    run;
    logic signed [7:0]       alu_y;

    logic [3:0]              selector;
    logic signed [7:0]       data_out;
    logic signed [7:0]       result_q;
    logic                    done;
    logic                    busy;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    alu_state_t              state;

    modport master (
        output sw_sel, sw_data, push, step, run, alu_y,
        input  selector, data_out, result_q, done, busy, count, full, empty, overflow, state
    );

    modport slave (
        input  sw_sel, sw_data, push, step, run, alu_y,
        output selector, data_out, result_q, done, busy, count, full, empty, overflow, state
    );

endinterface

// File: rtl/op_fifo.sv
// Circular FIFO of {sel, data} operation entries; a push while full is still
// accepted when a pop happens in the same cycle.
module op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  op_entry_t              din,
    output op_entry_t              dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    op_entry_t        mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues operations from switches and replays them to an external ALU,
// holding selector/operand for a settle window before capturing the result.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int         DEPTH         = 8,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] IDLE_SEL      = IDLE_SEL_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave bus
);

    localparam int SCW = $clog2(SETTLE_CYCLES + 1);

    logic                   push_q;
    logic                   step_q;
    logic                   run_q;
    logic                   push_edge;
    logic                   step_edge;
    logic                   run_edge;

    alu_state_t             state;
    logic [SCW-1:0]         settle_cnt;
    logic [3:0]             selector_r;
    logic [7:0]             data_r;
    logic [7:0]             result_r;
    logic                   done_r;
    logic                   overflow_r;

    logic                   fifo_pop;
    op_entry_t              fifo_din;
    op_entry_t              fifo_dout;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   start_from_idle;
    logic                   start_from_capture;

    assign push_edge = bus.push && !push_q;
    assign step_edge = bus.step && !step_q;
    assign run_edge  = bus.run  && !run_q;

    assign fifo_din = make_entry(bus.sw_sel, bus.sw_data);
    // The head is latched into selector on entry to ISSUE and removed during
    // ISSUE, so a push arriving in that cycle still finds room in a full queue.
    assign fifo_pop = (state == ST_ISSUE);

    assign start_from_idle    = !fifo_empty && (step_edge || run_edge || bus.run);
    assign start_from_capture = !fifo_empty && bus.run;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_edge),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q     <= 1'b0;
            step_q     <= 1'b0;
            run_q      <= 1'b0;
            state      <= ST_IDLE;
            settle_cnt <= '0;
            selector_r <= IDLE_SEL;
            data_r     <= '0;
            result_r   <= '0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            push_q <= bus.push;
            step_q <= bus.step;
            run_q  <= bus.run;
            done_r <= 1'b0;

            if (push_edge && fifo_full && !fifo_pop) begin
                overflow_r <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_from_idle) begin
                        state      <= ST_ISSUE;
                        selector_r <= fifo_dout.sel;
                        data_r     <= fifo_dout.data;
                    end
                end
                ST_ISSUE: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= SCW'(SETTLE_CYCLES);
                end
                ST_SETTLE: begin
                    if (settle_cnt <= SCW'(1)) begin
                        state      <= ST_CAPTURE;
                        settle_cnt <= '0;
                        result_r   <= bus.alu_y;
                        done_r     <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (start_from_capture) begin
                        state      <= ST_ISSUE;
                        selector_r <= fifo_dout.sel;
                        data_r     <= fifo_dout.data;
                    end else begin
                        state      <= ST_IDLE;
                        selector_r <= IDLE_SEL;
                        data_r     <= '0;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    selector_r <= IDLE_SEL;
                    data_r     <= '0;
                end
            endcase
        end
    end

    assign bus.selector = selector_r;
    assign bus.data_out = data_r;
    assign bus.result_q = result_r;
    assign bus.done     = done_r;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.count    = fifo_count;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.overflow = overflow_r;
    assign bus.state    = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small ALU model and a
// scoreboard of {selector, data, result} expected at each done pulse.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int         DEPTH = 8;
    localparam int         S     = 2;
    localparam logic [3:0] ISEL  = 4'h0;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   done_cnt = 0;
    int   done_cyc[$];
    logic [19:0] exp_q[$];
    logic [19:0] mon_got;
    logic [19:0] mon_exp;

    logic [3:0] tab_sel  [9] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h0, 4'h1, 4'h4, 4'h2, 4'h5};
    logic [7:0] tab_data [9] = '{8'h01, 8'h00, 8'hA7, 8'h00, 8'h80, 8'h7F, 8'h11, 8'h81, 8'h5A};
    logic [7:0] tab_res  [9] = '{8'h04, 8'hFD, 8'h07, 8'hFF, 8'h87, 8'h82, 8'h11, 8'h7E, 8'hA5};

    alu_op_sequencer_if #(.DEPTH(DEPTH)) bus ();

    alu_op_sequencer #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (S),
        .IDLE_SEL      (ISEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model ALU: NOP +7, ADD +3, SUB -3, AND 0x0F, XOR 0xFF, others pass.
    always_comb begin
        case (bus.selector)
            4'h0:    bus.alu_y = bus.data_out + 8'sd7;
            4'h1:    bus.alu_y = bus.data_out + 8'sd3;
            4'h2:    bus.alu_y = bus.data_out - 8'sd3;
            4'h3:    bus.alu_y = bus.data_out & 8'sh0F;
            4'h5:    bus.alu_y = bus.data_out ^ 8'shFF;
            default: bus.alu_y = bus.data_out;
        endcase
    end

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            total++;
            mon_got = {bus.selector, bus.data_out, bus.result_q};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got %05h with empty scoreboard", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL result_order: got %05h want %05h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic push_op(input logic [3:0] sel, input logic [7:0] d,
                           input logic [7:0] res, input bit accept);
        @(posedge clk); #1;
        bus.sw_sel  = sel;
        bus.sw_data = d;
        bus.push    = 1'b1;
        if (accept) exp_q.push_back({sel, d, res});
        @(posedge clk); #1;
        bus.push = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic step_pulse();
        @(posedge clk); #1;
        bus.step = 1'b1;
        @(posedge clk); #1;
        bus.step = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || !bus.empty) && n < max_cyc);
        check(name, (bus.busy || !bus.empty) ? 0 : 1, 1);
    endtask

    task automatic wait_state(input string name, input alu_state_t target, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.state != target && n < max_cyc);
        check(name, (bus.state == target) ? 1 : 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        bit got;

        reset = 1'b1;
        bus.sw_sel = '0; bus.sw_data = '0; bus.push = 1'b0; bus.step = 1'b0; bus.run = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_state",    int'(bus.state), int'(ST_IDLE));
        check("rst_selector", bus.selector, ISEL);
        check("rst_data_out", bus.data_out, 0);
        check("rst_result",   bus.result_q, 0);
        check("rst_done",     bus.done, 0);
        check("rst_busy",     bus.busy, 0);
        check("rst_count",    bus.count, 0);
        check("rst_empty",    bus.empty, 1);
        check("rst_overflow", bus.overflow, 0);

        // Single op by step: latency and ISSUE-time drive values
        push_op(4'h0, 8'h05, 8'h0C, 1'b1);
        @(posedge clk); #1;
        bus.step = 1'b1;
        n = 0; got = 1'b0;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (n == 2) begin
                check("issue_state",    int'(bus.state), int'(ST_ISSUE));
                check("issue_selector", bus.selector, 4'h0);
                check("issue_data_out", bus.data_out, 5);
                bus.step = 1'b0;
            end
            if (bus.done) got = 1'b1;
        end
        check("step_latency", got ? n : -1, S + 3);
        check("t1_result", bus.result_q, 8'h0C);
        @(negedge clk);
        check("t1_empty", bus.empty, 1);
        check("t1_busy",  bus.busy, 0);

        // Run back-to-back: spacing and return to idle
        push_op(4'h1, 8'h0A, 8'h0D, 1'b1);
        push_op(4'h2, 8'h04, 8'h01, 1'b1);
        push_op(4'h5, 8'h0F, 8'hF0, 1'b1);
        check("t2_count", bus.count, 3);
        base = done_cyc.size();
        bus.run = 1'b1;
        n = 0;
        while (done_cyc.size() < base + 3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("t2_three_dones", done_cyc.size() - base, 3);
        if (done_cyc.size() >= base + 3) begin
            check("t2_spacing_a", done_cyc[base+1] - done_cyc[base], S + 2);
            check("t2_spacing_b", done_cyc[base+2] - done_cyc[base+1], S + 2);
        end
        @(negedge clk);
        check("t2_busy_low",     bus.busy, 0);
        check("t2_idle_sel",     bus.selector, ISEL);
        check("t2_idle_data",    bus.data_out, 0);
        @(posedge clk); #1;
        bus.run = 1'b0;

        // Step held high: only one operation issues
        push_op(4'h3, 8'h3C, 8'h0C, 1'b1);
        push_op(4'h0, 8'hFE, 8'h05, 1'b1);
        base = done_cnt;
        @(posedge clk); #1;
        bus.step = 1'b1;
        repeat (10) @(posedge clk);
        #1 bus.step = 1'b0;
        @(negedge clk);
        check("t3_one_issue", done_cnt - base, 1);
        check("t3_count",     bus.count, 1);
        step_pulse();
        wait_idle("t3_drain", 30);

        // Overflow: nine pushes into an eight-deep queue
        for (int i = 0; i < 9; i++) begin
            push_op(tab_sel[i], tab_data[i], tab_res[i], i < 8);
            if (i == 7) begin
                check("t4_full_after_8", bus.full, 1);
                check("t4_count_8",      bus.count, 8);
                check("t4_no_ovf_yet",   bus.overflow, 0);
            end
        end
        check("t4_overflow", bus.overflow, 1);
        check("t4_count",    bus.count, 8);
        check("t4_full",     bus.full, 1);

        reset = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t4_rst_overflow", bus.overflow, 0);
        check("t4_rst_count",    bus.count, 0);

        // Full queue, run high, push during ISSUE
        for (int i = 0; i < 8; i++) push_op(tab_sel[i], tab_data[i], tab_res[i], 1'b1);
        check("t5_full", bus.full, 1);
        @(posedge clk); #1;
        bus.run = 1'b1;
        wait_state("t5_reach_issue", ST_ISSUE, 5);
        bus.sw_sel  = tab_sel[8];
        bus.sw_data = tab_data[8];
        bus.push    = 1'b1;
        exp_q.push_back({tab_sel[8], tab_data[8], tab_res[8]});
        @(negedge clk);
        bus.push = 1'b0;
        check("t5_count_stays", bus.count, 8);
        check("t5_no_overflow", bus.overflow, 0);
        wait_idle("t5_drain", 80);
        check("t5_overflow_end", bus.overflow, 0);
        @(posedge clk); #1;
        bus.run = 1'b0;

        // Reset during SETTLE
        push_op(4'h1, 8'h0A, 8'h0D, 1'b1);
        push_op(4'h2, 8'h04, 8'h01, 1'b1);
        step_pulse();
        wait_state("t6_reach_settle", ST_SETTLE, 10);
        reset = 1'b1;
        exp_q.delete();
        base = done_cnt;
        @(negedge clk);
        check("t6_state",    int'(bus.state), int'(ST_IDLE));
        check("t6_selector", bus.selector, ISEL);
        check("t6_count",    bus.count, 0);
        check("t6_result",   bus.result_q, 0);
        check("t6_done",     bus.done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt - base, 0);
        check("t6_busy",    bus.busy, 0);

        check("scoreboard_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
